// File: rtl/pipe_mult_param_if.sv
// Streaming handshake bundle for pipe_mult_param: operand side (valid/ready +
// a, b, is_signed) and product side (valid/ready + result), plus occupancy.
interface pipe_mult_param_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
);
  localparam int OW = $clog2(STAGES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic [OW-1:0]        occupancy;
  logic                 busy;

  // Producer / consumer side: drives operands and out_ready.
  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, result, occupancy, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, result, occupancy, busy
  );
endinterface

// File: rtl/pipe_mult_param.sv
// Parametrised pipelined multiplier with valid/ready back-pressure.
// Stage 1 registers the operands, stage 2 forms the full product, stages
// 3..STAGES delay it; the last stage is the registered output. All stages
// advance together when the output is empty or being consumed; bubbles are
// kept. Bubble data is forced to zero so result reads 0 whenever no product
// is presented.
module pipe_mult_param #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_mult_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int OW = $clog2(STAGES + 1);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);
  localparam logic [OW-1:0] OCC_MAX = OW'(STAGES);

  // Exact product: extend both operands to full width (sign or zero) and keep
  // the low PW bits, which is exact for two's-complement and unsigned alike.
  function automatic logic [PW-1:0] mul_f(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic             sgn);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    if (sgn) begin
      xe = {{WIDTH{x[WIDTH-1]}}, x};
      ye = {{WIDTH{y[WIDTH-1]}}, y};
    end else begin
      xe = {{WIDTH{1'b0}}, x};
      ye = {{WIDTH{1'b0}}, y};
    end
    return xe * ye;
  endfunction

  logic              adv_s;
  logic              accept_s;
  logic              retire_s;

  logic [STAGES:1]   valid_q, valid_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [PW-1:0]     prod_q [2:STAGES];
  logic [PW-1:0]     prod_d [2:STAGES];
  logic [OW-1:0]     occ_q, occ_d;
  logic              busy_q, busy_d;

  // Handshake decode: the whole pipe moves unless a result is stuck at the output.
  always_comb begin
    adv_s    = !valid_q[STAGES] || bus.out_ready;
    accept_s = bus.in_valid && adv_s;
    retire_s = valid_q[STAGES] && bus.out_ready;
  end

  // Next-state for stage valids, data and occupancy.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    prod_d  = prod_q;
    occ_d   = occ_q;

    if (adv_s) begin
      valid_d = {valid_q[STAGES-1:1], accept_s};
      if (accept_s) begin
        a_d   = bus.a;
        b_d   = bus.b;
        sgn_d = bus.is_signed;
      end else begin
        a_d   = {WIDTH{1'b0}};
        b_d   = {WIDTH{1'b0}};
        sgn_d = 1'b0;
      end
      prod_d[2] = mul_f(a_q, b_q, sgn_q);
      for (int i = 3; i <= STAGES; i++) begin
        prod_d[i] = prod_q[i-1];
      end
    end else begin
      valid_d = valid_q;
    end

    if (accept_s && !retire_s && (occ_q < OCC_MAX)) begin
      occ_d = occ_q + OCC_ONE;
    end else if (retire_s && !accept_s && (occ_q != {OW{1'b0}})) begin
      occ_d = occ_q - OCC_ONE;
    end else begin
      occ_d = occ_q;
    end

    busy_d = (occ_d != {OW{1'b0}});
  end

  // Pipeline and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= {STAGES{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sgn_q   <= 1'b0;
      for (int i = 2; i <= STAGES; i++) begin
        prod_q[i] <= {PW{1'b0}};
      end
      occ_q   <= {OW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      prod_q  <= prod_d;
      occ_q   <= occ_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = valid_q[STAGES];
  assign bus.result    = prod_q[STAGES];
  assign bus.occupancy = occ_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pipe_mult_param.sv
// Directed bench for pipe_mult_param: an 8x8/3-stage instance and a
// 16x16/5-stage instance, checked with immediate assertions.
module tb_pipe_mult_param;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   got1  = 0;
  int   got2  = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  pipe_mult_param_if #(.WIDTH(8),  .STAGES(3)) bus1 ();
  pipe_mult_param_if #(.WIDTH(16), .STAGES(5)) bus2 ();

  pipe_mult_param #(.WIDTH(8),  .STAGES(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_mult_param #(.WIDTH(16), .STAGES(5)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Reference product via integer arithmetic on a w-bit operand pair.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic s);
    longint xi, yi, p, mask;
    xi = longint'(x);
    yi = longint'(y);
    if (s && x[w-1]) xi = xi - (longint'(1) << w);
    if (s && y[w-1]) yi = yi - (longint'(1) << w);
    p    = xi * yi;
    mask = (longint'(1) << (2 * w)) - 1;
    return 32'(p & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One streaming cycle on the 8-bit instance with scoreboard bookkeeping.
  task automatic cyc1(input logic ordy, output logic acc);
    bus1.out_ready = ordy;
    #1;
    acc = bus1.in_valid && bus1.in_ready;
    if (acc) q1.push_back(ref_mul(8, {8'h00, bus1.a}, {8'h00, bus1.b}, bus1.is_signed));
    if (bus1.out_valid && bus1.out_ready) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $error("FAIL spurious_out1 observed=%0h expected=none", bus1.result);
      end else begin
        tests--;
        chk("stream1_result", {16'h0000, bus1.result}, q1.pop_front());
        got1++;
      end
    end
    tick();
    chk("stream1_occ", {29'd0, bus1.occupancy}, q1.size());
  endtask

  // One streaming cycle on the 16-bit instance with scoreboard bookkeeping.
  task automatic cyc2(input logic ordy, output logic acc);
    bus2.out_ready = ordy;
    #1;
    acc = bus2.in_valid && bus2.in_ready;
    if (acc) q2.push_back(ref_mul(16, bus2.a, bus2.b, bus2.is_signed));
    if (bus2.out_valid && bus2.out_ready) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $error("FAIL spurious_out2 observed=%0h expected=none", bus2.result);
      end else begin
        tests--;
        chk("stream2_result", bus2.result, q2.pop_front());
        got2++;
      end
    end
    tick();
    chk("stream2_occ", {29'd0, bus2.occupancy}, q2.size());
  endtask

  initial begin
    logic acc;
    logic ordy;
    int   next;
    int   stalls;
    int   n;
    logic [15:0] va [20];
    logic [15:0] vb [20];
    logic        vs [20];

    // Reset with operands presented: nothing may be accepted.
    rst_n = 1'b0;
    bus1.in_valid = 1'b1; bus1.a = 8'h12; bus1.b = 8'h34; bus1.is_signed = 1'b0;
    bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = 16'h0000; bus2.b = 16'h0000; bus2.is_signed = 1'b0;
    bus2.out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {31'd0, bus1.out_valid}, 32'd0);
    chk("rst_result",    {16'd0, bus1.result},    32'd0);
    chk("rst_occ",       {30'd0, bus1.occupancy}, 32'd0);
    chk("rst_busy",      {31'd0, bus1.busy},      32'd0);
    chk("rst_occ2",      {29'd0, bus2.occupancy}, 32'd0);
    rst_n = 1'b1;
    bus1.in_valid = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, bus1.in_ready},  32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_ghost", {31'd0, bus1.out_valid}, 32'd0);
    end

    // Unsigned 255*255, single pulse.
    bus1.in_valid = 1'b1; bus1.a = 8'd255; bus1.b = 8'd255; bus1.is_signed = 1'b0;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    chk("u_lat_early", {31'd0, bus1.out_valid}, 32'd0);
    tick();
    chk("u_valid",  {31'd0, bus1.out_valid}, 32'd1);
    chk("u_result", {16'd0, bus1.result},    32'h0000FE01);
    tick();
    chk("u_one_cycle", {31'd0, bus1.out_valid}, 32'd0);
    chk("u_idle_result", {16'd0, bus1.result}, 32'd0);

    // Signed back-to-back.
    bus1.in_valid = 1'b1; bus1.is_signed = 1'b1; bus1.a = 8'h80; bus1.b = 8'h80;
    tick();
    chk("s_occ1",  {30'd0, bus1.occupancy}, 32'd1);
    chk("s_busy1", {31'd0, bus1.busy},      32'd1);
    bus1.a = 8'hFF; bus1.b = 8'h01;
    tick();
    bus1.a = 8'h7F; bus1.b = 8'h80;
    tick();
    bus1.in_valid = 1'b0;
    chk("s_v0",   {31'd0, bus1.out_valid}, 32'd1);
    chk("s_r0",   {16'd0, bus1.result},    32'h00004000);
    chk("s_peak", {30'd0, bus1.occupancy}, 32'd3);
    tick();
    chk("s_r1",   {16'd0, bus1.result},    32'h0000FFFF);
    chk("s_occ2", {30'd0, bus1.occupancy}, 32'd2);
    tick();
    chk("s_r2",   {16'd0, bus1.result},    32'h0000C080);
    tick();
    chk("s_drained_v",    {31'd0, bus1.out_valid}, 32'd0);
    chk("s_drained_occ",  {30'd0, bus1.occupancy}, 32'd0);
    chk("s_drained_busy", {31'd0, bus1.busy},      32'd0);

    // Back-pressure: 6 ops, 4-cycle stall starting when the first result shows.
    next = 0; stalls = 0; got1 = 0;
    for (int c = 0; c < 40 && (next < 6 || q1.size() != 0); c++) begin
      bus1.in_valid = (next < 6);
      bus1.a = 8'(next * 29 + 3);
      bus1.b = 8'(250 - next * 17);
      bus1.is_signed = next[0];
      ordy = 1'b1;
      if (bus1.out_valid && stalls < 4) begin
        ordy = 1'b0;
        stalls++;
        bus1.out_ready = 1'b0;
        #1;
        chk("bp_in_ready", {31'd0, bus1.in_ready}, 32'd0);
        chk("bp_frozen",   {16'd0, bus1.result},   q1[0]);
        chk("bp_occ",      {30'd0, bus1.occupancy}, 32'd3);
      end
      cyc1(ordy, acc);
      if (acc) next++;
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    chk("bp_count",  got1, 32'd6);
    chk("bp_stalls", stalls, 32'd4);
    chk("bp_empty",  q1.size(), 32'd0);

    // Reset mid-operation.
    bus1.in_valid = 1'b1; bus1.is_signed = 1'b0; bus1.a = 8'd10; bus1.b = 8'd11;
    tick();
    bus1.a = 8'd12;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus1.in_valid = 1'b0;
    chk("mr_occ", {30'd0, bus1.occupancy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mr_no_out", {31'd0, bus1.out_valid}, 32'd0);
      tick();
    end
    bus1.in_valid = 1'b1; bus1.a = 8'd200; bus1.b = 8'd3;
    tick();
    bus1.in_valid = 1'b0;
    tick(); tick();
    chk("mr_new_valid",  {31'd0, bus1.out_valid}, 32'd1);
    chk("mr_new_result", {16'd0, bus1.result},    32'h00000258);
    tick();

    // 16x16, 5 stages: latency then random stream.
    bus2.in_valid = 1'b1; bus2.a = 16'hFFFF; bus2.b = 16'h0002; bus2.is_signed = 1'b1;
    tick();
    bus2.in_valid = 1'b0;
    n = 1;
    while (!bus2.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("w16_latency", n, 32'd5);
    chk("w16_result",  bus2.result, 32'hFFFFFFFE);
    tick();

    va[0] = 16'h8000; vb[0] = 16'h8000; vs[0] = 1'b1;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vs[1] = 1'b0;
    for (int i = 2; i < 20; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vs[i] = 1'($urandom);
    end
    chk("w16_ref_minmin", ref_mul(16, va[0], vb[0], vs[0]), 32'h40000000);
    chk("w16_ref_maxmax", ref_mul(16, va[1], vb[1], vs[1]), 32'hFFFE0001);
    next = 0; got2 = 0;
    for (int c = 0; c < 400 && (next < 20 || q2.size() != 0); c++) begin
      bus2.in_valid = (next < 20);
      bus2.a = va[next % 20];
      bus2.b = vb[next % 20];
      bus2.is_signed = vs[next % 20];
      cyc2(($urandom_range(0, 3) != 0), acc);
      if (acc) next++;
    end
    bus2.in_valid = 1'b0;
    chk("w16_count", got2, 32'd20);
    chk("w16_empty", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_mult_param.md
# pipe_mult_param

Parametrised pipelined multiplier, the successor to our fixed 8x8 registered-input/registered-output multiplier. It multiplies two WIDTH-bit operands, selectable signed or unsigned per operation, and produces a 2*WIDTH-bit product after a configurable number of pipeline stages. A valid/ready handshake with back-pressure lets it drop into streaming datapaths between the CLA adders and downstream accumulators. It also reports pipeline occupancy.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (>= 2)
- STAGES, 3, pipeline depth = latency in cycles (>= 2); stage 1 is the input register, stage STAGES is the output register

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low; one clock domain, no other reset
- in_valid  input  1  operands present
- in_ready  output  1  pipeline can accept this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
- out_valid  output  1  result holds a valid product
- out_ready  input  1  consumer takes result this cycle
- result  output  2*WIDTH  product, registered
- occupancy  output  $clog2(STAGES+1)  number of valid stages in flight
- busy  output  1  occupancy != 0

## Operation
- Each stage holds a valid bit plus its data; a, b and is_signed travel together.
- Advance condition: adv = !out_valid || out_ready. When adv = 1 all stages shift by one. When adv = 0 all stages hold, including bubbles; bubbles are not squeezed out.
- in_ready = adv, combinational from out_valid and out_ready. An input is accepted when in_valid && in_ready.
- Arithmetic:
  - Unsigned: result = a * b, zero-extended to 2*WIDTH.
  - Signed: operands are sign-extended to 2*WIDTH, multiplied, and truncated to 2*WIDTH, giving an exact two's-complement product.
  - No overflow is possible. The product of the two most-negative operands (-2^(WIDTH-1) squared) is representable and exact.
- The multiply may be split across stages 2..STAGES-1 (for example, partial-product rows summed per stage) or computed in stage 2 and delayed. Only latency and result are architectural.
- Occupancy counter:
  - Increments on accept without retire.
  - Decrements on retire (out_valid && out_ready) without accept.
  - Unchanged when both or neither occur.
  - Never exceeds STAGES and never underflows.
- Data registers of invalid stages are don't-care internally. result must nevertheless read 0 whenever out_valid = 0 after reset until the first product arrives.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - All valid bits, out_valid, occupancy and busy become 0.
  - result becomes 0 and data registers clear to 0.
  - in_ready becomes 1 in the cycle after reset.
- Reset mid-operation discards all in-flight operations. Inputs presented while rst_n = 0 are not accepted.
- Latency: an operand accepted at edge k appears with out_valid = 1 after edge k+STAGES-1 (visible during cycle k+STAGES), assuming no stall. Each stall cycle adds one cycle.
- Throughput is one operation per cycle when out_ready is held at 1.
- Stall:
  - While out_valid && !out_ready, result, out_valid and all internal stages are held stable.
  - in_ready = 0, so no input is accepted.
- Simultaneous accept and retire in one cycle: occupancy is unchanged and the data flows normally.
- out_ready is ignored while out_valid = 0.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, result = 0, occupancy = 0, busy = 0, no operation emerges later.
- Unsigned, WIDTH = 8, STAGES = 3: a = 255, b = 255, is_signed = 0, one-cycle pulse -> out_valid for exactly one cycle, result = 0xFE01, 3 cycles after accept.
- Signed, WIDTH = 8: (-128)*(-128) -> 0x4000; (-1)*1 -> 0xFFFF; 127*(-128) -> 0xC080. Issue back to back -> results arrive on 3 consecutive cycles in order; occupancy peaks at 3.
- Back-pressure: stream 6 ops with out_ready = 0 from the cycle the first result appears, for 4 cycles -> in_ready = 0, result frozen, occupancy = 3. On release, all 6 results arrive in order with none lost or duplicated.
- Reset mid-operation: accept 2 ops, assert rst_n = 0 one cycle later -> no out_valid afterwards, occupancy = 0. A new op after reset completes normally.
- Parameter sweep: WIDTH = 16, STAGES = 5, random signed/unsigned operands against a reference model -> bit-exact results with 5-cycle latency under random out_ready.
